// File: rtl/hist_pkg.sv
// Shared definitions for the histogram engine.
// Holds the default parameter values and the controller state encoding,
// so the top level and any bench agree on the same values.
package hist_pkg;

  localparam int PIXEL_W_DEF = 8;
  localparam int BIN_W_DEF   = 8;
  localparam int COUNT_W_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_ARMED = 3'd2;
  localparam state_t ST_ACCUM = 3'd3;
  localparam state_t ST_FLUSH = 3'd4;
  localparam state_t ST_COPY  = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/dp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Latency: read data valid one cycle after raddr; read-during-write returns old data.
// Backpressure: none, both ports accept an operation every cycle.
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata, raddr/rdata.
module dp_bram #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/histogram_engine_p.sv
// Frame histogram: counts pixels per bin over one armed frame, then publishes to a result RAM.
// Latency: 3-stage accumulate pipeline, 2-cycle flush, 2^BIN_W+2 cycle copy, 1-cycle done.
// Backpressure: none, a beat is taken every cycle in_valid is high; start ignored while busy.
// Ports: clk, rst_n, start, in_pixel/in_valid/in_sof/in_eof pixel stream,
//        rd_addr/rd_data result read, busy, done, saturated, frame_pixels.
module histogram_engine_p
  import hist_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int BIN_W   = BIN_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic               in_eof,
  input  logic [BIN_W-1:0]   rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic               saturated,
  output logic [31:0]        frame_pixels
);

  localparam int NBINS = 1 << BIN_W;
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
  localparam logic [BIN_W:0]     CNT_LAST  = (BIN_W+1)'(NBINS - 1);
  localparam logic [BIN_W:0]     CNT_NBINS = (BIN_W+1)'(NBINS);
  localparam logic [BIN_W:0]     CNT_CEND  = (BIN_W+1)'(NBINS + 1);

  state_t           state;
  logic [BIN_W:0]   cnt;
  logic             acc_beat;

  logic             v0, v1, fw_vld;
  logic [BIN_W-1:0] bin0, bin1, fw_bin;
  logic [COUNT_W-1:0] fw_dat, operand, inc_dat;
  logic             inc_sat;

  logic             acc_we;
  logic [BIN_W-1:0] acc_waddr, acc_raddr, copy_addr;
  logic [COUNT_W-1:0] acc_wdata, acc_rdata;
  logic             copy_wr;

  logic             sat_int;
  logic [31:0]      pix_int;

  assign acc_beat = in_valid && (((state == ST_ARMED) && in_sof) || (state == ST_ACCUM));
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // The bin written last cycle is not yet visible to this cycle's read
  // (the RAM returns old data on a same-cycle collision), so take it from
  // the forwarding register instead.
  assign operand = (fw_vld && (fw_bin == bin1)) ? fw_dat : acc_rdata;
  assign inc_sat = (operand == CNT_MAX);
  assign inc_dat = inc_sat ? operand : operand + COUNT_W'(1);

  // Copy reads bin cnt and writes bin cnt-1 one cycle later; cnt runs to
  // NBINS+1 so the final cycle is a spare drain cycle.
  assign copy_wr   = (state == ST_COPY) && (cnt != '0) && (cnt <= CNT_NBINS);
  assign copy_addr = cnt[BIN_W-1:0] - BIN_W'(1);

  always_comb begin
    acc_we    = v1;
    acc_waddr = bin1;
    acc_wdata = inc_dat;
    acc_raddr = bin0;
    if (state == ST_INIT) begin
      acc_we    = 1'b1;
      acc_waddr = cnt[BIN_W-1:0];
      acc_wdata = '0;
    end else if (state == ST_COPY) begin
      acc_we    = copy_wr;
      acc_waddr = copy_addr;
      acc_wdata = '0;
      acc_raddr = cnt[BIN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + (BIN_W+1)'(1);
          end
        end
        ST_IDLE:  if (start) state <= ST_ARMED;
        ST_ARMED: if (in_valid && in_sof) state <= in_eof ? ST_FLUSH : ST_ACCUM;
        ST_ACCUM: if (in_valid && in_eof) state <= ST_FLUSH;
        ST_FLUSH: begin
          if (cnt == (BIN_W+1)'(1)) begin
            state <= ST_COPY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + (BIN_W+1)'(1);
          end
        end
        ST_COPY: begin
          if (cnt == CNT_CEND) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + (BIN_W+1)'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0     <= 1'b0;
      v1     <= 1'b0;
      fw_vld <= 1'b0;
      bin0   <= '0;
      bin1   <= '0;
      fw_bin <= '0;
      fw_dat <= '0;
    end else begin
      v0     <= acc_beat;
      bin0   <= in_pixel[PIXEL_W-1 -: BIN_W];
      v1     <= v0;
      bin1   <= bin0;
      fw_vld <= v1;
      fw_bin <= bin1;
      fw_dat <= inc_dat;
    end
  end

  // Published results change on the edge into DONE so they are already
  // valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_int      <= 1'b0;
      pix_int      <= '0;
      saturated    <= 1'b0;
      frame_pixels <= '0;
    end else if ((state == ST_COPY) && (cnt == CNT_CEND)) begin
      saturated    <= sat_int;
      frame_pixels <= pix_int;
      sat_int      <= 1'b0;
      pix_int      <= '0;
    end else begin
      if (acc_beat)         pix_int <= pix_int + 32'd1;
      if (v1 && inc_sat)    sat_int <= 1'b1;
    end
  end

  dp_bram #(.DEPTH(NBINS), .WIDTH(COUNT_W)) u_acc_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (acc_we),
    .waddr (acc_waddr),
    .wdata (acc_wdata),
    .raddr (acc_raddr),
    .rdata (acc_rdata)
  );

  dp_bram #(.DEPTH(NBINS), .WIDTH(COUNT_W)) u_res_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (copy_wr),
    .waddr (copy_addr),
    .wdata (acc_rdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_histogram_engine_p.sv
// Bench for histogram_engine_p: a 16-bit and a 4-bit counter instance share one stimulus.
// A frame-level model (bin counts from the accepted beats, clipped per width) predicts results.
// Results are swept through rd_addr after each frame and checked on every read cycle.
module tb_histogram_engine_p;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, in_sof, in_eof;
  logic [7:0]  in_pixel, rd_addr;
  logic [15:0] rd_data_a;
  logic [3:0]  rd_data_b;
  logic        busy_a, done_a, sat_a, busy_b, done_b, sat_b;
  logic [31:0] pix_a, pix_b;

  histogram_engine_p u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_sof(in_sof), .in_eof(in_eof), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .busy(busy_a), .done(done_a), .saturated(sat_a), .frame_pixels(pix_a)
  );

  histogram_engine_p #(.COUNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_sof(in_sof), .in_eof(in_eof), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .busy(busy_b), .done(done_b), .saturated(sat_b), .frame_pixels(pix_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  localparam int M_IDLE = 0, M_ARMED = 1, M_ACCUM = 2, M_WAIT = 3;
  int mode = M_IDLE;
  int m_cnt [256];
  int m_pix = 0;
  int res_a [256];
  int res_b [256];

  logic       rd_chk = 1'b0;
  logic       rd_chk_q = 1'b0;
  logic [7:0] rd_addr_q = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input cycle; the model applies the frame rules to every valid beat.
  task automatic drive(input logic [7:0] pix, input logic v, input logic s, input logic e);
    in_pixel = pix; in_valid = v; in_sof = s; in_eof = e;
    if (v) begin
      if (mode == M_ARMED && s) begin
        m_cnt[pix]++; m_pix++;
        mode = e ? M_WAIT : M_ACCUM;
      end else if (mode == M_ACCUM) begin
        m_cnt[pix]++; m_pix++;
        if (e) mode = M_WAIT;
      end
    end
    tick();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++)
      drive(8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    if (mode == M_IDLE) mode = M_ARMED;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (mode != M_IDLE && i < 2000) begin
      tick();
      i++;
    end
    n_cmp++;
    if (mode != M_IDLE) begin
      n_err++;
      $display("FAIL done_timeout: got no done, expected done within 2000 cycles");
      mode = M_IDLE;
    end
    check("idle_after_done", busy_a, 0);
  endtask

  task automatic read_bin(input logic [7:0] a, output int va, output int vb);
    rd_addr = a;
    tick();
    va = rd_data_a;
    vb = rd_data_b;
  endtask

  task automatic sweep();
    rd_chk = 1'b1;
    for (int a = 0; a < 256; a++) begin
      rd_addr = 8'(a);
      tick();
    end
    rd_chk = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_pixel = '0;
    #1;
    check("rst_busy", busy_a, 1);
    check("rst_done", done_a, 0);
    check("rst_saturated", sat_a, 0);
    check("rst_frame_pixels", pix_a, 0);
    check("rst_rd_data", rd_data_a, 0);
    check("rst_rd_data_b", rd_data_b, 0);
    for (int b = 0; b < 256; b++) m_cnt[b] = 0;
    m_pix = 0;
    mode = M_IDLE;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("busy_after_release", busy_a, 1);
    begin
      int c;
      c = 0;
      do begin
        tick();
        c++;
      end while (busy_a && c < 1000);
      check("init_cycles", c, 256);
    end
  endtask

  // Compare process: read-back data and the done-cycle outputs.
  always @(negedge clk) begin
    if (rd_chk_q) begin
      check($sformatf("rd_a[%0d]", rd_addr_q), rd_data_a, res_a[rd_addr_q]);
      check($sformatf("rd_b[%0d]", rd_addr_q), rd_data_b, res_b[rd_addr_q]);
    end
    rd_chk_q  = rd_chk;
    rd_addr_q = rd_addr;
    if (rst_n === 1'b1 && (done_a || done_b)) begin
      int sa, sb;
      sa = 0; sb = 0;
      for (int b = 0; b < 256; b++) begin
        if (m_cnt[b] > 65535) sa = 1;
        if (m_cnt[b] > 15)    sb = 1;
      end
      check("done_expected", mode, M_WAIT);
      check("done_a", done_a, 1);
      check("done_b", done_b, 1);
      check("frame_pixels_a", pix_a, m_pix);
      check("frame_pixels_b", pix_b, m_pix);
      check("saturated_a", sat_a, sa);
      check("saturated_b", sat_b, sb);
      for (int b = 0; b < 256; b++) begin
        res_a[b] = (m_cnt[b] > 65535) ? 65535 : m_cnt[b];
        res_b[b] = (m_cnt[b] > 15) ? 15 : m_cnt[b];
        m_cnt[b] = 0;
      end
      m_pix = 0;
      mode  = M_IDLE;
    end
  end

  initial begin
    int va, vb;
    rd_addr = '0;
    start = 1'b0;
    for (int b = 0; b < 256; b++) begin
      m_cnt[b] = 0; res_a[b] = 0; res_b[b] = 0;
    end

    do_reset();

    // Single-beat frame.
    pulse_start();
    gap(2);
    drive(8'h40, 1'b1, 1'b1, 1'b1);
    wait_done();
    check("t1_frame_pixels", pix_a, 1);
    read_bin(8'h40, va, vb);
    check("t1_bin40", va, 1);
    read_bin(8'h41, va, vb);
    check("t1_bin41", va, 0);
    sweep();

    // 1000 back-to-back beats on one bin.
    pulse_start();
    for (int i = 0; i < 1000; i++)
      drive(8'h7F, 1'b1, 1'(i == 0), 1'(i == 999));
    wait_done();
    check("t2_frame_pixels", pix_a, 1000);
    check("t2_sat_a", sat_a, 0);
    check("t2_sat_b", sat_b, 1);
    read_bin(8'h7F, va, vb);
    check("t2_bin7f_a", va, 1000);
    check("t2_bin7f_b", vb, 15);
    sweep();

    // Alternating bins with random idle gaps.
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      drive((i % 2 == 0) ? 8'h10 : 8'h11, 1'b1, 1'(i == 0), 1'(i == 999));
      gap($urandom_range(0, 2));
    end
    wait_done();
    read_bin(8'h10, va, vb);
    check("t3_bin10", va, 500);
    read_bin(8'h11, va, vb);
    check("t3_bin11", va, 500);
    sweep();

    // Clipping on the narrow instance, then a clean frame.
    pulse_start();
    for (int i = 0; i < 20; i++)
      drive(8'h05, 1'b1, 1'(i == 0), 1'(i == 19));
    wait_done();
    check("t4_sat_b", sat_b, 1);
    read_bin(8'h05, va, vb);
    check("t4_bin05_b", vb, 15);
    check("t4_bin05_a", va, 20);
    pulse_start();
    for (int i = 0; i < 3; i++)
      drive(8'h06, 1'b1, 1'(i == 0), 1'(i == 2));
    wait_done();
    check("t4b_sat_b", sat_b, 0);
    read_bin(8'h06, va, vb);
    check("t4b_bin06_b", vb, 3);
    sweep();

    // Pre-sof beats, stray sof/eof and start pulses while busy.
    pulse_start();
    drive(8'h30, 1'b1, 1'b0, 1'b0);
    drive(8'h30, 1'b1, 1'b0, 1'b1);
    pulse_start();
    drive(8'h30, 1'b1, 1'b0, 1'b1);
    drive(8'h30, 1'b1, 1'b1, 1'b0);
    drive(8'h30, 1'b1, 1'b0, 1'b0);
    pulse_start();
    drive(8'h30, 1'b1, 1'b1, 1'b0);
    drive(8'h30, 1'b1, 1'b0, 1'b0);
    drive(8'h30, 1'b1, 1'b0, 1'b1);
    pulse_start();
    gap(10);
    pulse_start();
    wait_done();
    check("t5_frame_pixels", pix_a, 5);
    read_bin(8'h30, va, vb);
    check("t5_bin30", va, 5);
    pulse_start();
    for (int i = 0; i < 3; i++)
      drive(8'h31, 1'b1, 1'(i == 0), 1'(i == 2));
    wait_done();
    read_bin(8'h30, va, vb);
    check("t5b_bin30", va, 0);
    read_bin(8'h31, va, vb);
    check("t5b_bin31", va, 3);
    sweep();

    // Reset in the middle of a frame; result RAM must survive.
    pulse_start();
    for (int i = 0; i < 5; i++)
      drive(8'h50, 1'b1, 1'(i == 0), 1'b0);
    do_reset();
    sweep();
    pulse_start();
    for (int i = 0; i < 10; i++)
      drive(8'h20, 1'b1, 1'(i == 0), 1'(i == 9));
    wait_done();
    check("t6_frame_pixels", pix_a, 10);
    read_bin(8'h20, va, vb);
    check("t6_bin20", va, 10);
    read_bin(8'h50, va, vb);
    check("t6_bin50", va, 0);
    sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
